// File: rtl/present_bus_master.sv
// rtl/present_bus_master.sv - bus initiator running one PRESENT job over the 4-bit-address register bus
module present_bus_master #(
    parameter int LOAD_GAP  = 2,
    parameter int MAX_POLLS = 64
) (
    input  logic        clk,
    input  logic        iResetn,
    input  logic        iStart,
    input  logic [79:0] iKey,
    input  logic [63:0] iBlock,
    input  logic        iMode,
    output logic        oBusy,
    output logic        oDone,
    output logic        oError,
    output logic [63:0] oResult,
    output logic        oChipselect,
    output logic        oWriteRead,
    output logic [3:0]  oAddress,
    output logic [31:0] oWdat,
    input  logic [31:0] iRdat
);
    typedef enum logic [3:0] {
        IDLE, W_CTRL, W_K1, W_K2, W_K3, W_D1, W_D2, W_LOAD,
        GAP, POLL_RD, POLL_CAP, R_HI, R_LO, FIN
    } state_t;

    typedef struct packed {
        logic        cs;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdat;
    } bus_t;

    function automatic bus_t wr_cyc(input logic [3:0] a, input logic [31:0] d);
        return bus_t'{1'b1, 1'b1, a, d};
    endfunction

    function automatic bus_t rd_cyc(input logic [3:0] a);
        return bus_t'{1'b1, 1'b0, a, 32'd0};
    endfunction

    state_t      state;
    bus_t        bus;
    logic [79:0] key_q;
    logic [63:0] blk_q;
    logic        mode_q;
    logic [7:0]  poll_cnt;
    logic [3:0]  gap_cnt;
    logic [31:0] hi_q;
    logic [63:0] res_q;
    logic [63:0] fin_result;

    assign {oChipselect, oWriteRead, oAddress, oWdat} = bus;

    // The low result word only arrives during FIN, so the result is muxed through while oDone is up.
    assign fin_result = oError ? 64'd0 : {hi_q, iRdat};
    assign oResult    = (state == FIN) ? fin_result : res_q;

    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            state    <= IDLE;
            bus      <= '0;
            key_q    <= '0;
            blk_q    <= '0;
            mode_q   <= 1'b0;
            poll_cnt <= '0;
            gap_cnt  <= '0;
            hi_q     <= '0;
            res_q    <= '0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
            oError   <= 1'b0;
        end else begin
            bus    <= '0;
            oDone  <= 1'b0;
            oError <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        key_q    <= iKey;
                        blk_q    <= iBlock;
                        mode_q   <= iMode;
                        poll_cnt <= '0;
                        oBusy    <= 1'b1;
                        bus      <= wr_cyc(4'd8, {31'b0, iMode});
                        state    <= W_CTRL;
                    end
                end
                W_CTRL: begin
                    bus   <= wr_cyc(4'd1, key_q[79:48]);
                    state <= W_K1;
                end
                W_K1: begin
                    bus   <= wr_cyc(4'd2, key_q[47:16]);
                    state <= W_K2;
                end
                W_K2: begin
                    bus   <= wr_cyc(4'd3, {16'b0, key_q[15:0]});
                    state <= W_K3;
                end
                W_K3: begin
                    bus   <= wr_cyc(4'd4, blk_q[63:32]);
                    state <= W_D1;
                end
                W_D1: begin
                    bus   <= wr_cyc(4'd5, blk_q[31:0]);
                    state <= W_D2;
                end
                W_D2: begin
                    bus   <= wr_cyc(4'd0, {31'b0, 1'b1});
                    state <= W_LOAD;
                end
                W_LOAD: begin
                    gap_cnt <= 4'd1;
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt == 4'(LOAD_GAP)) begin
                        bus      <= rd_cyc(4'd8);
                        poll_cnt <= poll_cnt + 8'd1;
                        state    <= POLL_RD;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                POLL_RD: state <= POLL_CAP;
                POLL_CAP: begin
                    if (iRdat[0]) begin
                        bus   <= rd_cyc(4'd6);
                        state <= R_HI;
                    end else if (poll_cnt < 8'(MAX_POLLS)) begin
                        bus      <= rd_cyc(4'd8);
                        poll_cnt <= poll_cnt + 8'd1;
                        state    <= POLL_RD;
                    end else begin
                        oDone  <= 1'b1;
                        oError <= 1'b1;
                        state  <= FIN;
                    end
                end
                R_HI: begin
                    bus   <= rd_cyc(4'd7);
                    state <= R_LO;
                end
                R_LO: begin
                    hi_q  <= iRdat;
                    oDone <= 1'b1;
                    state <= FIN;
                end
                FIN: begin
                    res_q <= fin_result;
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_present_bus_master.sv
// tb/tb_present_bus_master.sv - directed bench for present_bus_master with a behavioural PRESENT slave
module tb_present_bus_master;
    localparam int LOAD_GAP  = 2;
    localparam int MAX_POLLS = 4;

    logic        clk = 1'b0;
    logic        iResetn = 1'b0;
    logic        iStart = 1'b0;
    logic [79:0] iKey = '0;
    logic [63:0] iBlock = '0;
    logic        iMode = 1'b0;
    logic        oBusy, oDone, oError, oChipselect, oWriteRead;
    logic [63:0] oResult;
    logic [3:0]  oAddress;
    logic [31:0] oWdat;
    logic [31:0] iRdat = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    present_bus_master #(.LOAD_GAP(LOAD_GAP), .MAX_POLLS(MAX_POLLS)) dut (
        .clk(clk), .iResetn(iResetn), .iStart(iStart), .iKey(iKey), .iBlock(iBlock),
        .iMode(iMode), .oBusy(oBusy), .oDone(oDone), .oError(oError), .oResult(oResult),
        .oChipselect(oChipselect), .oWriteRead(oWriteRead), .oAddress(oAddress),
        .oWdat(oWdat), .iRdat(iRdat)
    );

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] t;
        t = 64'h21748FE3DA09B65C;
        return t[4*x +: 4];
    endfunction

    function automatic logic [3:0] isbox(input logic [3:0] x);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) if (sbox(4'(i)) == x) r = 4'(i);
        return r;
    endfunction

    function automatic logic [63:0] sub_layer(input logic [63:0] s, input bit inv);
        logic [63:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) r[4*n +: 4] = inv ? isbox(s[4*n +: 4]) : sbox(s[4*n +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] s, input bit inv);
        logic [63:0] r;
        int p;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            p = (j == 63) ? 63 : (16 * j) % 63;
            if (inv) r[j] = s[p];
            else     r[p] = s[j];
        end
        return r;
    endfunction

    function automatic logic [63:0] present(input logic [79:0] key, input logic [63:0] b, input bit dec);
        logic [63:0] rk [1:32];
        logic [79:0] k;
        logic [63:0] s;
        k = key;
        for (int i = 1; i <= 32; i++) begin
            rk[i] = k[79:16];
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(i);
        end
        s = b;
        if (!dec) begin
            for (int i = 1; i <= 31; i++) s = p_layer(sub_layer(s ^ rk[i], 1'b0), 1'b0);
            s = s ^ rk[32];
        end else begin
            s = s ^ rk[32];
            for (int i = 31; i >= 1; i--) s = sub_layer(p_layer(s, 1'b1), 1'b1) ^ rk[i];
        end
        return s;
    endfunction

    // Behavioural register slave: registered read data, done after a programmable number of polls.
    logic [79:0] s_key = '0;
    logic [63:0] s_blk = '0;
    logic        s_mode = 1'b0;
    logic [63:0] s_res = '0;
    logic        s_load = 1'b0;
    int          s_polls = 0;
    int          done_after = 1;
    int          rd8 = 0;
    int          load_cycles = 0;
    logic [35:0] wlog [$];

    always @(posedge clk) begin
        if (s_load) load_cycles++;
        iRdat  <= 32'd0;
        s_load <= 1'b0;
        if (oChipselect && oWriteRead) begin
            wlog.push_back({oAddress, oWdat});
            case (oAddress)
                4'd0: begin
                    s_load <= oWdat[0];
                    if (oWdat[0]) begin
                        s_res   <= present(s_key, s_blk, s_mode);
                        s_polls <= 0;
                    end
                end
                4'd1: s_key[79:48] <= oWdat;
                4'd2: s_key[47:16] <= oWdat;
                4'd3: s_key[15:0]  <= oWdat[15:0];
                4'd4: s_blk[63:32] <= oWdat;
                4'd5: s_blk[31:0]  <= oWdat;
                4'd8: s_mode       <= oWdat[0];
                default: ;
            endcase
        end else if (oChipselect) begin
            case (oAddress)
                4'd6: iRdat <= s_res[63:32];
                4'd7: iRdat <= s_res[31:0];
                4'd8: begin
                    rd8++;
                    s_polls <= s_polls + 1;
                    iRdat   <= {31'b0, (done_after != 0) && (s_polls + 1 >= done_after)};
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [79:0] key;
        logic [63:0] blk;
        logic        mode;
        int          da;
        logic        err;
        logic [63:0] res;
        int          lat;
        int          polls;
    } vec_t;

    task automatic run_job(input vec_t v, input int pulse_at, input bit hold);
        int k;
        int busy_low;
        logic [35:0] wexp [7];
        logic [35:0] got;
        done_after  = v.da;
        rd8         = 0;
        load_cycles = 0;
        wlog.delete();
        @(negedge clk);
        chk("idle_before", {63'd0, oBusy}, 64'd0);
        iKey = v.key; iBlock = v.blk; iMode = v.mode; iStart = 1'b1;
        @(posedge clk);
        k = 0;
        busy_low = 0;
        do begin
            @(negedge clk);
            k++;
            if (!hold && k == 1) iStart = 1'b0;
            if (pulse_at != 0) iStart = (k == pulse_at);
            if (!oBusy) busy_low++;
        end while (!oDone && k < 300);
        chk("latency", 64'(k), 64'(v.lat));
        chk("error", {63'd0, oError}, {63'd0, v.err});
        chk("result", oResult, v.res);
        chk("busy_span", 64'(busy_low), 64'd0);
        chk("poll_reads", 64'(rd8), 64'(v.polls));
        chk("load_cycles", 64'(load_cycles), 64'd1);
        chk("write_count", 64'(wlog.size()), 64'd7);
        wexp[0] = {4'd8, 31'b0, v.mode};
        wexp[1] = {4'd1, v.key[79:48]};
        wexp[2] = {4'd2, v.key[47:16]};
        wexp[3] = {4'd3, 16'b0, v.key[15:0]};
        wexp[4] = {4'd4, v.blk[63:32]};
        wexp[5] = {4'd5, v.blk[31:0]};
        wexp[6] = {4'd0, 32'd1};
        for (int i = 0; i < 7; i++) begin
            got = (i < wlog.size()) ? wlog[i] : '1;
            chk($sformatf("write%0d", i), 64'(got), 64'(wexp[i]));
        end
        if (!hold) begin
            @(negedge clk);
            chk("busy_after", {63'd0, oBusy}, 64'd0);
            chk("done_after", {63'd0, oDone}, 64'd0);
            chk("cs_after", {63'd0, oChipselect}, 64'd0);
            chk("result_held", oResult, v.res);
        end
    endtask

    vec_t vt [4];
    vec_t vr;
    int   dones;

    initial begin
        vt[0] = '{80'h0, 64'h0, 1'b0, 1, 1'b0, 64'h5579C1387B228445, 14, 1};
        vt[1] = '{{80{1'b1}}, 64'h0, 1'b0, 3, 1'b0, 64'hE72C46C0F5945049, 18, 3};
        vt[2] = '{80'h0, 64'h0123456789ABCDEF, 1'b0, 0, 1'b1, 64'h0, 18, 4};
        vt[3] = '{{80{1'b1}}, 64'hE72C46C0F5945049, 1'b1, 2, 1'b0, 64'h0, 16, 2};

        repeat (3) @(negedge clk);
        chk("rst_outputs", {oBusy, oDone, oError, oChipselect, oWriteRead, oAddress, oWdat, 24'd0},
            64'd0);
        chk("rst_result", oResult, 64'd0);
        iResetn = 1'b1;

        for (int i = 0; i < 4; i++) run_job(vt[i], 0, 1'b0);

        // Start request mid-job must be dropped without queueing.
        run_job(vt[0], 3, 1'b0);
        repeat (5) @(negedge clk);
        chk("no_extra_writes", 64'(wlog.size()), 64'd7);
        chk("no_extra_job", {63'd0, oBusy}, 64'd0);

        // Reset partway through a job.
        done_after = 1;
        @(negedge clk);
        iKey = '0; iBlock = '0; iMode = 1'b0; iStart = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iStart = 1'b0;
        repeat (4) @(negedge clk);
        iResetn = 1'b0;
        #1;
        chk("midrst_outputs", {oBusy, oDone, oError, oChipselect, oWriteRead, oAddress, oWdat, 24'd0},
            64'd0);
        chk("midrst_result", oResult, 64'd0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (oDone) dones++;
        end
        iResetn = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (oDone) dones++;
        end
        chk("midrst_no_done", 64'(dones), 64'd0);
        chk("midrst_bus_idle", {63'd0, oChipselect}, 64'd0);
        vr = '{{80{1'b1}}, 64'h0, 1'b1, 1, 1'b0, present({80{1'b1}}, 64'h0, 1'b1), 14, 1};
        run_job(vr, 0, 1'b0);
        chk("ctrl_mode1", 64'(wlog.size() > 0 ? wlog[0] : 36'h0), 64'({4'd8, 32'h1}));

        // Start held high across two back-to-back jobs.
        run_job(vt[1], 0, 1'b1);
        run_job(vt[0], 0, 1'b1);
        @(negedge clk);
        iStart = 1'b0;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
